// File: rtl/wm_cycle_ctrl_p.sv
// -----------------------------------------------------------------------------
// wm_cycle_ctrl_p
// Parametrised washing-machine cycle controller. Walks SOAK -> WASH -> RINSE
// -> SPIN using a per-mode phase-time table. A phase whose time is zero is
// skipped. An internal prescaler turns TICK_DIV clk cycles into one "minute"
// tick. Opening the lid during a running phase pauses it, and closing the lid
// resumes it.
//
// Optional feature: WM_DOOR_LOCK_EN
//   When this macro is defined, the block gains a door_lock output. The door
//   is held locked through all running phases, so the lid input is ignored
//   there and the PAUSE state can never be reached.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   lid                   1 = lid open
//   coin                  coin present (level, sampled)
//   cancel                abort request
//   start                 start the cycle from READY
//   mode [MODE_W]         program select, latched on start
//   idle_op..pause_op     one-hot state indicators (registered)
//   water_inlet           valve drive, high in SOAK or RINSE
//   coin_rtn              one-cycle refund pulse on cancel from READY
//   phase_done            one-cycle pulse when a phase expires
//   cycle_done            one-cycle pulse when the cycle completes into IDLE
//   remaining_min[TIME_W] minutes left in the current or paused phase
//   door_lock             (WM_DOOR_LOCK_EN only) high in SOAK..SPIN
// -----------------------------------------------------------------------------
module wm_cycle_ctrl_p #(
  parameter int MODE_W   = 2,
  parameter int TIME_W   = 4,
  parameter int TICK_DIV = 60,
  parameter logic [(2**MODE_W)*TIME_W-1:0] SOAK_TIMES  = 16'h0321,
  parameter logic [(2**MODE_W)*TIME_W-1:0] WASH_TIMES  = 16'h1532,
  parameter logic [(2**MODE_W)*TIME_W-1:0] RINSE_TIMES = 16'h1532,
  parameter logic [(2**MODE_W)*TIME_W-1:0] SPIN_TIMES  = 16'h1532
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lid,
  input  logic              coin,
  input  logic              cancel,
  input  logic              start,
  input  logic [MODE_W-1:0] mode,
  output logic              idle_op,
  output logic              ready_op,
  output logic              soak_op,
  output logic              wash_op,
  output logic              rinse_op,
  output logic              spin_op,
  output logic              pause_op,
  output logic              water_inlet,
  output logic              coin_rtn,
  output logic              phase_done,
  output logic              cycle_done,
`ifdef WM_DOOR_LOCK_EN
  output logic              door_lock,
`endif
  output logic [TIME_W-1:0] remaining_min
);

  localparam int NUM_MODES = 2**MODE_W;
  localparam int PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

`ifdef WM_DOOR_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_SOAK  = 3'd2,
    ST_WASH  = 3'd3,
    ST_RINSE = 3'd4,
    ST_SPIN  = 3'd5,
    ST_PAUSE = 3'd6
  } state_t;

  // Look up the time of phase idx (0 = soak .. 3 = spin) for mode m.
  function automatic logic [TIME_W-1:0] phase_time(input logic [1:0] idx,
                                                   input logic [MODE_W-1:0] m);
    logic [NUM_MODES*TIME_W-1:0] tbl;
    case (idx)
      2'd0:    tbl = SOAK_TIMES;
      2'd1:    tbl = WASH_TIMES;
      2'd2:    tbl = RINSE_TIMES;
      default: tbl = SPIN_TIMES;
    endcase
    return tbl[int'(m)*TIME_W +: TIME_W];
  endfunction

  // First phase at or after index 'from' that has a nonzero time. Returns
  // IDLE when every remaining phase is zero, which ends the cycle.
  function automatic state_t first_phase(input int from,
                                         input logic [MODE_W-1:0] m);
    state_t r;
    r = ST_IDLE;
    for (int i = 3; i >= 0; i--) begin
      if (i >= from && phase_time(2'(i), m) != '0) r = state_t'(3'(i + 2));
    end
    return r;
  endfunction

  function automatic logic [1:0] phase_idx(input state_t s);
    return 2'(s - ST_SOAK);
  endfunction

  function automatic logic is_running(input state_t s);
    return (s == ST_SOAK) || (s == ST_WASH) || (s == ST_RINSE) || (s == ST_SPIN);
  endfunction

  state_t              state, state_nx, resume, resume_nx;
  logic [PRE_W-1:0]    presc, presc_nx;
  logic [TIME_W-1:0]   count, count_nx;
  logic [MODE_W-1:0]   mode_l, mode_nx;
  logic                coin_rtn_nx, phase_done_nx, cycle_done_nx;
  logic [TIME_W-1:0]   rem_nx;
  logic                lid_pause;

  // With the door locked, an open-lid reading never pauses a phase.
  assign lid_pause = lid & ~LOCK_EN;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nx      = state;
    resume_nx     = resume;
    presc_nx      = presc;
    count_nx      = count;
    mode_nx       = mode_l;
    coin_rtn_nx   = 1'b0;
    phase_done_nx = 1'b0;
    cycle_done_nx = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!cancel && !lid && coin) state_nx = ST_READY;
      end

      ST_READY: begin
        if (cancel) begin
          state_nx    = ST_IDLE;
          coin_rtn_nx = 1'b1;
        end else if (start && !lid) begin
          mode_nx  = mode;
          state_nx = first_phase(0, mode);
          presc_nx = '0;
          count_nx = '0;
          if (state_nx == ST_IDLE) cycle_done_nx = 1'b1;
        end
      end

      ST_SOAK, ST_WASH, ST_RINSE, ST_SPIN: begin
        if (cancel) begin
          state_nx = ST_IDLE;
          presc_nx = '0;
          count_nx = '0;
        end else if (lid_pause) begin
          // Counters hold, so the tick this cycle (even an expiry) is deferred.
          state_nx  = ST_PAUSE;
          resume_nx = state;
        end else if (presc == PRE_W'(TICK_DIV - 1)) begin
          presc_nx = '0;
          if (count + TIME_W'(1) == phase_time(phase_idx(state), mode_l)) begin
            count_nx      = '0;
            phase_done_nx = 1'b1;
            state_nx      = first_phase(int'(phase_idx(state)) + 1, mode_l);
            if (state_nx == ST_IDLE) cycle_done_nx = 1'b1;
          end else begin
            count_nx = count + TIME_W'(1);
          end
        end else begin
          presc_nx = presc + PRE_W'(1);
        end
      end

      ST_PAUSE: begin
        if (cancel) begin
          state_nx = ST_IDLE;
          presc_nx = '0;
          count_nx = '0;
        end else if (!lid) begin
          state_nx = resume;
        end
      end

      default: state_nx = ST_IDLE;
    endcase

    // Readout tracks the phase being timed, including a paused one.
    if (is_running(state_nx))
      rem_nx = phase_time(phase_idx(state_nx), mode_nx) - count_nx;
    else if (state_nx == ST_PAUSE)
      rem_nx = phase_time(phase_idx(resume_nx), mode_nx) - count_nx;
    else
      rem_nx = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      resume        <= ST_IDLE;
      presc         <= '0;
      count         <= '0;
      mode_l        <= '0;
      idle_op       <= 1'b1;
      ready_op      <= 1'b0;
      soak_op       <= 1'b0;
      wash_op       <= 1'b0;
      rinse_op      <= 1'b0;
      spin_op       <= 1'b0;
      pause_op      <= 1'b0;
      water_inlet   <= 1'b0;
      coin_rtn      <= 1'b0;
      phase_done    <= 1'b0;
      cycle_done    <= 1'b0;
      remaining_min <= '0;
`ifdef WM_DOOR_LOCK_EN
      door_lock     <= 1'b0;
`endif
    end else begin
      state         <= state_nx;
      resume        <= resume_nx;
      presc         <= presc_nx;
      count         <= count_nx;
      mode_l        <= mode_nx;
      idle_op       <= (state_nx == ST_IDLE);
      ready_op      <= (state_nx == ST_READY);
      soak_op       <= (state_nx == ST_SOAK);
      wash_op       <= (state_nx == ST_WASH);
      rinse_op      <= (state_nx == ST_RINSE);
      spin_op       <= (state_nx == ST_SPIN);
      pause_op      <= (state_nx == ST_PAUSE);
      water_inlet   <= (state_nx == ST_SOAK) || (state_nx == ST_RINSE);
      coin_rtn      <= coin_rtn_nx;
      phase_done    <= phase_done_nx;
      cycle_done    <= cycle_done_nx;
      remaining_min <= rem_nx;
`ifdef WM_DOOR_LOCK_EN
      door_lock     <= is_running(state_nx);
`endif
    end
  end

endmodule

// File: doc/wm_cycle_ctrl_p.md
Name: wm_cycle_ctrl_p

Overview:
Parametrised washing-machine cycle controller, successor to the fixed 3-mode controller. It supports a per-mode phase-time table, an internal minute prescaler, lid-open pause/resume, phases that are skipped when their time is zero, and a remaining-time readout. It sits between the front-panel inputs (lid, coin, cancel, start, mode) and the actuator drivers (water inlet, motor phase indicators).

Parameters:
- MODE_W, 2, mode select width; NUM_MODES = 2**MODE_W.
- TIME_W, 4, width of each phase time in minutes.
- TICK_DIV, 60, clk cycles per "minute" tick; must be ≥ 1.
- SOAK_TIMES, 16'h0321, packed NUM_MODES×TIME_W; mode m uses slice [m*TIME_W +: TIME_W].
- WASH_TIMES, 16'h1532, as above.
- RINSE_TIMES, 16'h1532, as above.
- SPIN_TIMES, 16'h1532, as above.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lid  in  1  1 = lid open.
- coin  in  1  coin inserted (level, sampled).
- cancel  in  1  abort request.
- start  in  1  start cycle from READY.
- mode  in  MODE_W  program select.
- idle_op, ready_op, soak_op, wash_op, rinse_op, spin_op, pause_op  out  1 each  state indicators.
- water_inlet  out  1  high in SOAK or RINSE (not PAUSE).
- coin_rtn  out  1  one-cycle refund pulse.
- phase_done  out  1  one-cycle pulse when a phase expires.
- cycle_done  out  1  one-cycle pulse on completion to IDLE.
- remaining_min  out  TIME_W  minutes left in the current phase (phase_time − count); 0 in IDLE/READY.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; prescaler, count, latched mode, resume register = 0; all pulses 0. Outputs: idle_op=1, all other outputs 0.
- State register plus registered outputs update on rising clk only. No negedge logic.
- States: IDLE, READY, SOAK, WASH, RINSE, SPIN, PAUSE.
- Priority each cycle: cancel > lid > tick/expiry > start/coin.
- IDLE: coin=1 & lid=0 & cancel=0 → READY.
- READY:
  - cancel=1 → IDLE with coin_rtn=1 for exactly one cycle.
  - start=1 & lid=0 → latch mode, then enter the first phase with nonzero time.
  - If all four times are zero, go straight to IDLE with cycle_done=1.
  - coin while in READY is ignored.
- Running phase (SOAK..SPIN):
  - Prescaler counts 0..TICK_DIV−1; at TICK_DIV−1 a tick fires, prescaler wraps, count increments.
  - The tick where count+1 == phase_time ends the phase. On that edge: phase_done=1, go to the next phase with nonzero time; prescaler and count clear.
  - After SPIN (or when no later phase is nonzero): → IDLE with cycle_done=1.
  - Each phase lasts exactly TICK_DIV×T cycles when not paused.
- Lid open (lid=1) in a running phase:
  - → PAUSE; the resume register stores the phase; prescaler and count freeze.
  - PAUSE + lid=0 → return to the stored phase and resume counting from the frozen value.
  - A lid opening on the expiry cycle wins: the phase does not expire until resumed.
- cancel=1 in any running state or PAUSE → IDLE. No coin_rtn, no done pulses; counters clear.
- lid=1 in READY: stays in READY; start is ignored.
- Mode changes after start have no effect; the latched mode is used until IDLE.
- Arithmetic: count is TIME_W bits and never exceeds phase_time−1; remaining_min is never negative.
- Reset mid-cycle: immediate return to IDLE regardless of state.

Optional Feature:
WM_DOOR_LOCK_EN
- Defined: adds output door_lock (1 bit, reset 0). door_lock is high in SOAK, WASH, RINSE and SPIN. While door_lock=1, lid=1 is ignored (no PAUSE; timing continues). cancel still aborts, and door_lock drops on the cycle IDLE is entered. PAUSE is unreachable.
- Undefined: no door_lock port; lid-open pause/resume works as described above.

Test Plan:
- TICK_DIV=4, mode=0. Sequence: coin, then start; no pause. → SOAK 4 cycles, WASH 8, RINSE 8, SPIN 8. Four phase_done pulses, then cycle_done; idle_op=1 at cycle 29 after start.
- mode=3 (soak=0). Sequence: start. → enters WASH directly; soak_op never asserts; WASH/RINSE/SPIN last 4 cycles each.
- mode=1, TICK_DIV=4. Sequence: lid=1 for 10 cycles at WASH cycle 5, then lid=0. → pause_op high, water_inlet=0, remaining_min frozen at 2. Resume completes WASH after 7 more cycles.
- Sequence: cancel in READY. → coin_rtn high exactly 1 cycle, then IDLE. Sequence: cancel in RINSE. → IDLE, coin_rtn=0, cycle_done=0.
- Sequence: rst_n low mid-SPIN (asynchronous, between edges). → idle_op=1 and all other outputs 0 immediately. Sequence: coin after rst_n releases. → READY.
- With WM_DOOR_LOCK_EN defined. Sequence: lid=1 during SOAK. → no PAUSE, door_lock=1, SOAK ends on schedule; door_lock=0 after cycle_done.
